// File: rtl/s3511_rtc_core.sv
// s3511_rtc_core: S-3511A style serial RTC front end (cs/sck/din/dout) with a
// free-running BCD calendar, host load/snapshot and a minute interrupt.
module s3511_rtc_core #(
  parameter int unsigned TICK_DIV    = 16777216,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        cs,
  input  logic        sck,
  input  logic        din,
  output logic        dout,
  input  logic        load,
  input  logic [55:0] load_time,
  output logic [55:0] cur_time,
  output logic [7:0]  status,
  output logic        int_n
);

  localparam int unsigned     PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [55:0]     CAL_RST   = 56'h00_01_01_00_00_00_00;
  localparam logic [1:0]      SEL_STAT  = 2'd1;
  localparam logic [1:0]      SEL_DT    = 2'd2;
  localparam logic [1:0]      SEL_TIME  = 2'd3;
  localparam logic [7:0]      STAT_WMSK = 8'h4A;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_RDATA  = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  // True when the field sits at (or beyond) its last legal value, or is not valid BCD.
  function automatic logic bcd_wraps(input logic [7:0] v, input logic [7:0] max_v);
    logic r;
    if ((v[3:0] > 4'd9) || (v[7:4] > 4'd9) || (v >= max_v)) r = 1'b1;
    else r = 1'b0;
    return r;
  endfunction

  // BCD increment; invalid or maxed fields are forced to their wrap value.
  function automatic logic [7:0] bcd_next(input logic [7:0] v, input logic [7:0] max_v,
                                          input logic [7:0] wrap_v);
    logic [7:0] r;
    if (bcd_wraps(v, max_v)) r = wrap_v;
    else if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
    else r = v + 8'd1;
    return r;
  endfunction

  // Last day of the month; BCD year mod 4 is (2*tens + units) mod 4, 00 is leap.
  function automatic logic [7:0] month_days(input logic [7:0] mon, input logic [7:0] yr);
    logic [1:0] ym4;
    logic [7:0] r;
    ym4 = yr[1:0] + {yr[4], 1'b0};
    case (mon)
      8'h02:                      r = (ym4 == 2'd0) ? 8'h29 : 8'h28;
      8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
      default:                    r = 8'h31;
    endcase
    return r;
  endfunction

  // One-second advance of the packed calendar; bit 56 is the second->minute carry.
  function automatic logic [56:0] cal_tick(input logic [55:0] c);
    logic [55:0] n;
    logic        cs_c, cm_c, ch_c, cd_c, cmo_c;
    logic [7:0]  dim;
    n    = c;
    dim  = month_days(c[47:40], c[55:48]);
    cs_c = bcd_wraps(c[7:0], 8'h59);
    cm_c = cs_c & bcd_wraps(c[15:8], 8'h59);
    ch_c = cm_c & bcd_wraps(c[23:16], 8'h23);
    cd_c = ch_c & bcd_wraps(c[39:32], dim);
    cmo_c = cd_c & bcd_wraps(c[47:40], 8'h12);
    n[7:0] = bcd_next(c[7:0], 8'h59, 8'h00);
    if (cs_c)  n[15:8]  = bcd_next(c[15:8], 8'h59, 8'h00);
    if (cm_c)  n[23:16] = bcd_next(c[23:16], 8'h23, 8'h00);
    if (ch_c)  n[39:32] = bcd_next(c[39:32], dim, 8'h01);
    if (ch_c)  n[31:24] = bcd_next(c[31:24], 8'h06, 8'h00);
    if (cd_c)  n[47:40] = bcd_next(c[47:40], 8'h12, 8'h01);
    if (cmo_c) n[55:48] = bcd_next(c[55:48], 8'h99, 8'h00);
    return {cs_c, n};
  endfunction

  // Byte count of each register group.
  function automatic logic [3:0] sel_bytes(input logic [1:0] sel);
    logic [3:0] r;
    case (sel)
      SEL_STAT: r = 4'd1;
      SEL_DT:   r = 4'd7;
      SEL_TIME: r = 4'd3;
      default:  r = 4'd0;
    endcase
    return r;
  endfunction

  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, din_sync_q;
  logic cs_prev_q, sck_prev_q;
  logic cs_s, sck_s, din_s, cs_rise_s, cs_fall_s, sck_rise_s, sck_fall_s;

  state_t           state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [3:0]       byte_cnt_q, byte_cnt_d;
  logic [7:0]       sh_q, sh_d;
  logic [1:0]       sel_q, sel_d;
  logic [6:0][7:0]  wbuf_q, wbuf_d;
  logic [55:0]      rd_sh_q, rd_sh_d;
  logic             dout_q, dout_d;
  logic [55:0]      cal_q, cal_d;
  logic [7:0]       status_q, status_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             int_n_q, int_n_d;

  logic [7:0]  cmd_s, wbyte_s, hour_rd_s, stat_new_s;
  logic        cal_wr_s, stat_wr_s, rd_clr_s, c0_s;
  logic [55:0] cal_new_s;
  logic [56:0] tick_s;

  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign sck_s      = sck_sync_q[SYNC_STAGES-1];
  assign din_s      = din_sync_q[SYNC_STAGES-1];
  assign cs_rise_s  = cs_s & ~cs_prev_q;
  assign cs_fall_s  = ~cs_s & cs_prev_q;
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign hour_rd_s  = cal_q[23:16] | ((cal_q[23:16] >= 8'h12) ? 8'h80 : 8'h00);
  assign stat_new_s = (status_q & ~STAT_WMSK) | (wbuf_q[0] & STAT_WMSK);

  // Synchronise the serial pins and keep the previous level for edge detection.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync_q  <= '0;
      sck_sync_q <= '0;
      din_sync_q <= '0;
      cs_prev_q  <= 1'b0;
      sck_prev_q <= 1'b0;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], din};
      cs_prev_q  <= cs_s;
      sck_prev_q <= sck_s;
    end
  end

  // Protocol FSM: command decode, write shadow, read snapshot and dout shifting.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    sh_d       = sh_q;
    sel_d      = sel_q;
    wbuf_d     = wbuf_q;
    rd_sh_d    = rd_sh_q;
    dout_d     = dout_q;
    cal_wr_s   = 1'b0;
    cal_new_s  = cal_q;
    stat_wr_s  = 1'b0;
    rd_clr_s   = 1'b0;
    c0_s       = 1'b0;
    cmd_s      = {sh_q[6:0], din_s};
    wbyte_s    = {din_s, sh_q[7:1]};
    if (cs_fall_s) begin
      state_d = ST_IDLE;
      dout_d  = 1'b1;
      if ((state_q == ST_WDATA) && (bit_cnt_q == 3'd0) && (byte_cnt_q == sel_bytes(sel_q))) begin
        case (sel_q)
          SEL_STAT: stat_wr_s = 1'b1;
          SEL_DT: begin
            cal_wr_s  = 1'b1;
            cal_new_s = {wbuf_q[0], wbuf_q[1], wbuf_q[2], wbuf_q[3],
                         wbuf_q[4] & 8'h7F, wbuf_q[5], wbuf_q[6]};
          end
          SEL_TIME: begin
            cal_wr_s  = 1'b1;
            cal_new_s = {cal_q[55:24], wbuf_q[0] & 8'h7F, wbuf_q[1], wbuf_q[2]};
          end
          default: stat_wr_s = 1'b0;
        endcase
      end else if ((state_q == ST_RDATA) && (sel_q == SEL_STAT)) begin
        rd_clr_s = 1'b1;
      end else begin
        rd_clr_s = 1'b0;
      end
    end else if (cs_rise_s) begin
      state_d    = ST_CMD;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = 4'd0;
      dout_d     = 1'b1;
    end else if (cs_s && sck_rise_s) begin
      case (state_q)
        ST_CMD: begin
          sh_d      = cmd_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            sel_d = cmd_s[2:1];
            if ((cmd_s[7:4] == 4'b0110) && (cmd_s[3:1] == 3'd0)) begin
              c0_s    = 1'b1;
              state_d = ST_IGNORE;
            end else if ((cmd_s[7:4] != 4'b0110) || cmd_s[3]) begin
              state_d = ST_IGNORE;
            end else if (cmd_s[0]) begin
              state_d = ST_RDATA;
              case (cmd_s[2:1])
                SEL_STAT: rd_sh_d = {48'hFFFF_FFFF_FFFF, status_q};
                SEL_DT:   rd_sh_d = {cal_q[7:0], cal_q[15:8], hour_rd_s, cal_q[31:24],
                                     cal_q[39:32], cal_q[47:40], cal_q[55:48]};
                default:  rd_sh_d = {32'hFFFF_FFFF, cal_q[7:0], cal_q[15:8], hour_rd_s};
              endcase
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_WDATA: begin
          sh_d      = wbyte_s;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q < 4'd7) wbuf_d[byte_cnt_q[2:0]] = wbyte_s;
            if (byte_cnt_q != 4'hF) byte_cnt_d = byte_cnt_q + 4'd1;
          end
        end
        default: state_d = state_q;
      endcase
    end else if (cs_s && sck_fall_s && (state_q == ST_RDATA)) begin
      dout_d  = rd_sh_q[0];
      rd_sh_d = {1'b1, rd_sh_q[55:1]};
    end else begin
      state_d = state_q;
    end
  end

  // Protocol FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 4'd0;
      sh_q       <= 8'h00;
      sel_q      <= 2'd0;
      wbuf_q     <= '0;
      rd_sh_q    <= '1;
      dout_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      sh_q       <= sh_d;
      sel_q      <= sel_d;
      wbuf_q     <= wbuf_d;
      rd_sh_q    <= rd_sh_d;
      dout_q     <= dout_d;
    end
  end

  // Calendar/status/prescaler next state: load > commit or clear > tick.
  always_comb begin
    cal_d    = cal_q;
    presc_d  = presc_q;
    status_d = status_q;
    int_n_d  = int_n_q;
    tick_s   = cal_tick(cal_q);
    if (load) begin
      cal_d   = load_time;
      presc_d = '0;
    end else if (c0_s) begin
      cal_d   = CAL_RST;
      presc_d = '0;
    end else if (cal_wr_s) begin
      cal_d   = cal_new_s;
      presc_d = '0;
    end else if (stat_wr_s) begin
      presc_d = '0;
    end else if (presc_q == PRESC_MAX) begin
      presc_d = '0;
      cal_d   = tick_s[55:0];
      int_n_d = ~(status_q[3] & tick_s[56]);
    end else begin
      presc_d = presc_q + PW'(1);
    end
    if (c0_s) begin
      status_d = 8'h00;
      int_n_d  = 1'b1;
    end else if (stat_wr_s) begin
      status_d = stat_new_s;
      if (!stat_new_s[3]) int_n_d = 1'b1;
      else int_n_d = int_n_q;
    end else if (rd_clr_s) begin
      status_d = status_q & 8'h7F;
    end else begin
      status_d = status_q;
    end
  end

  // Calendar, status, prescaler and interrupt registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cal_q    <= CAL_RST;
      status_q <= 8'h80;
      presc_q  <= '0;
      int_n_q  <= 1'b1;
    end else begin
      cal_q    <= cal_d;
      status_q <= status_d;
      presc_q  <= presc_d;
      int_n_q  <= int_n_d;
    end
  end

  assign dout     = dout_q;
  assign cur_time = cal_q;
  assign status   = status_q;
  assign int_n    = int_n_q;

endmodule

// File: doc/s3511_rtc_core.md
Name: s3511_rtc_core

Overview:
Parametrised successor to the S-3511A RTC front end: full serial protocol (commands, reads and writes), plus a free-running BCD calendar clock.
- Sits behind the cartridge GPIO pins (cs/sck/din/dout) in the GBA core.
- Adds what the first version lacks: read-back, reset/status commands, atomic commits, time counting with month/leap rollover, host load/snapshot and a minute interrupt.

Parameters:
TICK_DIV, 16777216, clock cycles per one-second tick (must be >=2)
SYNC_STAGES, 2, flops on cs/sck/din before edge detection (>=2)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous reset, active low
cs  in  1  serial chip select, active high
sck  in  1  serial clock
din  in  1  serial data in
dout  out  1  serial data out
load  in  1  one-cycle strobe: overwrite calendar with load_time
load_time  in  56  BCD {year[7:0],month[7:0],day[7:0],dow[7:0],hour[7:0],minute[7:0],second[7:0]}
cur_time  out  56  live calendar, same packing
status  out  8  status register
int_n  out  1  minute interrupt, active low

Behaviour:
- Reset (async, reset_n low): calendar = year 00, month 01, day 01, dow 0, 00:00:00; status = 0x80 (bit7 power-fail); dout=1; int_n=1; prescaler=0; protocol idle.
- cs, sck and din pass through SYNC_STAGES flops. Edges are detected on the synchronised signals. Latency pin -> action = SYNC_STAGES+1 cycles.
- Transaction states: IDLE, CMD, WDATA, RDATA, IGNORE.
  - Sync'd cs rising: go to CMD, bit/byte counters cleared.
  - Sync'd cs falling: from any state, go to IDLE.
- CMD: each sck rising edge shifts din MSB-first. After 8 bits the command completes:
  - bits[7:4] != 0110: go to IGNORE.
  - C = bits[3:1], RnW = bit0.
  - C=0: reset calendar to reset values, status=0x00, prescaler=0; go to IGNORE.
  - C=1: status, 1 byte.
  - C=2: datetime, 7 bytes.
  - C=3: time, 3 bytes (hour, minute, second).
  - C=4..7: go to IGNORE.
  - RnW=1: go to RDATA. RnW=0: go to WDATA.
- WDATA:
  - Bytes shift in LSB-first into a shadow buffer.
  - The commit happens on cs falling, and only if exactly the full byte count was received. Otherwise the shadow is discarded.
  - Status write stores bits 6,3,1 only; the other bits are unaffected.
  - Hour byte bit7 (PM) is ignored on write; hour is stored 00-23.
  - Commit sets prescaler=0.
- RDATA:
  - On command completion, snapshot the selected bytes. For hour, bit7 = PM (hour >= 0x12) is ORed in.
  - dout drives snapshot bit0 from the first sck falling edge after the 8th rising edge. Each later falling edge advances one bit, LSB-first through the bytes.
  - Past the last byte: dout=1.
  - Reading status clears status bit7 at cs falling.
- IGNORE: input discarded, dout=1. In IDLE and CMD, dout=1.
- Tick:
  - Prescaler counts 0..TICK_DIV-1 and issues a one-second tick on wrap.
  - BCD increment order: second 59->00 carries to minute; minute 59->00 carries to hour; hour 23->00 carries to day and dow.
  - dow wraps 6->0.
  - Day wraps past days-in-month: 31/30/28, or 29 in Feb when year mod 4 == 0 (BCD year, 00 counts as leap). On day wrap, month increments.
  - Month 12->01 increments year; year 99->00.
  - Invalid BCD written by the host or serial is stored as-is. Incrementing an invalid field forces it to its wrap value and carries.
- Priority in one cycle: async reset > load > serial commit/C=0 > tick. A lower-priority tick in the same cycle is dropped. load and commit also zero the prescaler.
- Counting continues during transactions; reads use the snapshot.
- int_n:
  - If status bit3=1, int_n goes low on a tick that causes a minute carry. It returns high on the next tick.
  - Clearing bit3 forces int_n=1 immediately on commit.
- cur_time and status are registered, updated the cycle after the event.

Test Plan:
- Reset, no activity -> cur_time=0x00_01_01_00_00_00_00, status=0x80, dout=1, int_n=1.
- Serial write cmd 0x64 + bytes 0x24,0x02,0x28,0x03,0x23,0x59,0x59, cs low; then 1 tick -> cur_time=0x24_02_29_04_00_00_00.
- Same as above with year 0x23 -> after tick, month/day = 0x03/0x01; dow=4.
- Write cmd 0x66 then only 2 bytes, cs low -> cur_time unchanged; prescaler not cleared.
- Read cmd 0x63 (status) after reset -> dout sequence on falling edges 0,0,0,0,0,0,0,1; status=0x00 after cs falls. Read 0x67 at 13:05:09 -> bytes 0x93,0x05,0x09 LSB-first.
- Status write 0x08 (cmd 0x62), load 00:00:59, 1 tick -> int_n low until next tick. Load asserted in the same cycle as a tick -> load value kept, no increment.
